// File: rtl/frame_config_ctrl.sv
// SPI-programmed frame configuration register: stages a 32-bit word and applies it at frame_start.
// Optional readback of the live configuration is compiled in when CFG_READBACK_EN is defined.
module frame_config_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        ss,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        frame_start,
  output logic [31:0] config_out,
  output logic        cfg_pending,
  output logic        cmd_error,
  output logic        busy,
  output logic [7:0]  tx_data
);

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
`ifdef CFG_READBACK_EN
    ,
    READ  = 2'd2
`endif
  } state_t;

  state_t      state, state_next;
  logic [1:0]  count, count_next;
  logic [31:0] shadow, shadow_next;
  logic [31:0] staged;
  logic [31:0] assembled;
  logic        ss_prev;
  logic        ss_rise;
  logic        load_staged;
  logic        err_next;

  assign ss_rise   = ss & ~ss_prev;
  assign assembled = {shadow[23:0], rx_data};
  assign busy      = (state != IDLE);

  always_comb begin
    state_next  = state;
    count_next  = count;
    shadow_next = shadow;
    load_staged = 1'b0;
    err_next    = 1'b0;
    if (ena) begin
      // Deselect mid-transaction wins over any byte arriving on the same edge.
      if (ss_rise && state != IDLE) begin
        state_next  = IDLE;
        count_next  = 2'd0;
        shadow_next = 32'd0;
        err_next    = (state == WRITE);
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == CMD_WRITE) begin
              state_next  = WRITE;
              count_next  = 2'd0;
              shadow_next = 32'd0;
`ifdef CFG_READBACK_EN
            end else if (rx_data == CMD_READ) begin
              state_next = READ;
              count_next = 2'd0;
`endif
            end else begin
              err_next = 1'b1;
            end
          end
          WRITE: begin
            if (count == 2'd3) begin
              load_staged = 1'b1;
              state_next  = IDLE;
              count_next  = 2'd0;
              shadow_next = 32'd0;
            end else begin
              shadow_next = assembled;
              count_next  = count + 2'd1;
            end
          end
`ifdef CFG_READBACK_EN
          READ: begin
            if (count == 2'd3) begin
              state_next = IDLE;
              count_next = 2'd0;
            end else begin
              count_next = count + 2'd1;
            end
          end
`endif
          default: begin
            state_next = IDLE;
            count_next = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 2'd0;
      shadow      <= 32'd0;
      staged      <= 32'd0;
      config_out  <= 32'd0;
      cfg_pending <= 1'b0;
      cmd_error   <= 1'b0;
      ss_prev     <= 1'b1;
    end else begin
      state     <= state_next;
      count     <= count_next;
      shadow    <= shadow_next;
      cmd_error <= err_next;
      ss_prev   <= ss;
      if (load_staged) begin
        staged <= assembled;
      end
      // A write completing on the frame_start edge defers to the next frame.
      if (load_staged) begin
        cfg_pending <= 1'b1;
      end else if (frame_start && cfg_pending) begin
        config_out  <= staged;
        cfg_pending <= 1'b0;
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [31:0] readback;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readback <= 32'd0;
    end else if (state == IDLE && state_next == READ) begin
      readback <= config_out;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == READ) begin
      case (count)
        2'd0:    tx_data = readback[31:24];
        2'd1:    tx_data = readback[23:16];
        2'd2:    tx_data = readback[15:8];
        default: tx_data = readback[7:0];
      endcase
    end
  end
`else
  assign tx_data = 8'h00;
`endif

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Directed self-checking bench for frame_config_ctrl; readback expectations follow CFG_READBACK_EN.
module tb_frame_config_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        ss = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        frame_start = 1'b0;
  logic [31:0] config_out;
  logic        cfg_pending;
  logic        cmd_error;
  logic        busy;
  logic [7:0]  tx_data;

  int errors = 0;
  int checks = 0;

  frame_config_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ss(ss), .rx_valid(rx_valid),
    .rx_data(rx_data), .frame_start(frame_start), .config_out(config_out),
    .cfg_pending(cfg_pending), .cmd_error(cmd_error), .busy(busy), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send_byte(input logic [7:0] b, input logic fs);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b; frame_start = fs;
    @(negedge clk);
    rx_valid = 1'b0; frame_start = 1'b0;
    $display("byte %h fs=%0d -> config_out=%h pending=%0d err=%0d busy=%0d tx=%h",
             b, fs, config_out, cfg_pending, cmd_error, busy, tx_data);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    $display("frame_start -> config_out=%h pending=%0d", config_out, cfg_pending);
  endtask

  task automatic write_word(input logic [31:0] w);
    send_byte(8'hA5, 1'b0);
    send_byte(w[31:24], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (config_out !== 32'h0) begin errors++; $display("FAIL reset_config: got %h exp %h", config_out, 32'h0); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b exp 0", cfg_pending); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", cmd_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h exp 00", tx_data); end
    @(negedge clk);
    rst_n = 1'b1; ss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    send_byte(8'hA5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b exp 1", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL write_tx: got %h exp 00", tx_data); end
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL write_early_pending: got %b exp 0", cfg_pending); end
    send_byte(8'h78, 1'b0);
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL write_pending: got %b exp 1", cfg_pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle: got %b exp 0", busy); end
    checks++; if (config_out !== 32'h0) begin errors++; $display("FAIL write_not_applied: got %h exp %h", config_out, 32'h0); end
    pulse_frame();
    checks++; if (config_out !== 32'h12345678) begin errors++; $display("FAIL write_applied: got %h exp %h", config_out, 32'h12345678); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL write_pending_clr: got %b exp 0", cfg_pending); end
    pulse_frame();
    checks++; if (config_out !== 32'h12345678) begin errors++; $display("FAIL frame_no_pending: got %h exp %h", config_out, 32'h12345678); end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h3C, 1'b0);
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL badcmd_err: got %b exp 1", cmd_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy: got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL badcmd_pulse: got %b exp 0", cmd_error); end
    checks++; if (config_out !== 32'h12345678) begin errors++; $display("FAIL badcmd_config: got %h exp %h", config_out, 32'h12345678); end
  endtask

  task automatic test_abort();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    ss = 1'b1;
    @(negedge clk);
    $display("ss rise -> err=%0d busy=%0d", cmd_error, busy);
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL abort_err: got %b exp 1", cmd_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL abort_pulse: got %b exp 0", cmd_error); end
    ss = 1'b0;
    pulse_frame();
    checks++; if (config_out !== 32'h12345678) begin errors++; $display("FAIL abort_config: got %h exp %h", config_out, 32'h12345678); end
    checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL abort_pending: got %b exp 0", cfg_pending); end
  endtask

  task automatic test_back_to_back();
    write_word(32'hAAAAAAAA);
    write_word(32'h55555555);
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending: got %b exp 1", cfg_pending); end
    pulse_frame();
    checks++; if (config_out !== 32'h55555555) begin errors++; $display("FAIL b2b_config: got %h exp %h", config_out, 32'h55555555); end
  endtask

  task automatic test_coincident();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    checks++; if (config_out !== 32'h55555555) begin errors++; $display("FAIL coinc_hold: got %h exp %h", config_out, 32'h55555555); end
    checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coinc_pending: got %b exp 1", cfg_pending); end
    pulse_frame();
    checks++; if (config_out !== 32'h01020304) begin errors++; $display("FAIL coinc_applied: got %h exp %h", config_out, 32'h01020304); end
  endtask

  task automatic test_ena();
    write_word(32'hCAFEF00D);
    ena = 1'b0;
    send_byte(8'hA5, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_ignore: got %b exp 0", busy); end
    pulse_frame();
    checks++; if (config_out !== 32'hCAFEF00D) begin errors++; $display("FAIL ena_frame: got %h exp %h", config_out, 32'hCAFEF00D); end
    ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h99, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    checks++; if (config_out !== 32'h0) begin errors++; $display("FAIL rstmid_config: got %h exp %h", config_out, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %b exp 0", cmd_error); end
    send_byte(8'h77, 1'b0);
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b exp 1", cmd_error); end
  endtask

  task automatic test_readback();
    write_word(32'hDEADBEEF);
    pulse_frame();
`ifdef CFG_READBACK_EN
    write_word(32'h01234567);
    send_byte(8'h5A, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b exp 1", busy); end
    checks++; if (tx_data !== 8'hDE) begin errors++; $display("FAIL rd_b0: got %h exp DE", tx_data); end
    pulse_frame();
    checks++; if (config_out !== 32'h01234567) begin errors++; $display("FAIL rd_frame: got %h exp %h", config_out, 32'h01234567); end
    checks++; if (tx_data !== 8'hDE) begin errors++; $display("FAIL rd_snapshot: got %h exp DE", tx_data); end
    send_byte(8'h00, 1'b0);
    checks++; if (tx_data !== 8'hAD) begin errors++; $display("FAIL rd_b1: got %h exp AD", tx_data); end
    send_byte(8'h00, 1'b0);
    checks++; if (tx_data !== 8'hBE) begin errors++; $display("FAIL rd_b2: got %h exp BE", tx_data); end
    send_byte(8'h00, 1'b0);
    checks++; if (tx_data !== 8'hEF) begin errors++; $display("FAIL rd_b3: got %h exp EF", tx_data); end
    send_byte(8'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_done: got %b exp 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rd_idle_tx: got %h exp 00", tx_data); end
    send_byte(8'h5A, 1'b0);
    ss = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_abort_busy: got %b exp 0", busy); end
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL rd_abort_err: got %b exp 0", cmd_error); end
    ss = 1'b0;
`else
    send_byte(8'h5A, 1'b0);
    checks++; if (cmd_error !== 1'b1) begin errors++; $display("FAIL rd_invalid_err: got %b exp 1", cmd_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_invalid_busy: got %b exp 0", busy); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rd_invalid_tx: got %h exp 00", tx_data); end
    checks++; if (config_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_invalid_cfg: got %h exp %h", config_out, 32'hDEADBEEF); end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_bad_cmd();
    test_abort();
    test_back_to_back();
    test_coincident();
    test_ena();
    test_readback();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
